// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, x/y raster counters, sync/blank decode
// and line/frame strobes, all outputs registered and aligned with x/y.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic               clock_100,
  input  logic               reset_n,
  input  logic               enable,
  output logic               p_tick,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               hsync,
  output logic               vsync,
  output logic               display_active,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SS   = H_ACTIVE + H_FP;
  localparam int unsigned H_SE   = H_SS + H_SYNC - 1;
  localparam int unsigned V_SS   = V_ACTIVE + V_FP;
  localparam int unsigned V_SE   = V_SS + V_SYNC - 1;
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(VT - 1);

  // Reject parameter sets the counters cannot represent.
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be within 1..16");
  end
  if (((HT - 1) >> CNT_W) != 0 || ((VT - 1) >> CNT_W) != 0) begin : g_bad_cnt
    $error("vga_timing_gen: CNT_W too small for HT-1 or VT-1");
  end
  if (FRAME_W < 1) begin : g_bad_frame
    $error("vga_timing_gen: FRAME_W must be at least 1");
  end

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_n;
  logic             advance;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] x_n;
  logic [CNT_W-1:0] y_n;
  logic             hsync_n;
  logic             vsync_n;
  logic             active_n;

  // Next-state counts; decode uses them so registered outputs line up with x/y.
  always_comb begin
    div_n    = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    advance  = p_tick & enable;
    h_wrap   = advance && (x == X_LAST);
    v_wrap   = h_wrap && (y == Y_LAST);
    x_n      = x;
    y_n      = y;
    if (advance) x_n = h_wrap ? '0 : x + CNT_W'(1);
    if (h_wrap)  y_n = v_wrap ? '0 : y + CNT_W'(1);
    hsync_n  = ((x_n >= CNT_W'(H_SS)) && (x_n <= CNT_W'(H_SE))) ? HSYNC_POL : ~HSYNC_POL;
    vsync_n  = ((y_n >= CNT_W'(V_SS)) && (y_n <= CNT_W'(V_SE))) ? VSYNC_POL : ~VSYNC_POL;
    active_n = enable && (x_n < CNT_W'(H_ACTIVE)) && (y_n < CNT_W'(V_ACTIVE));
  end

  // p_tick is a flop mirroring div==CLK_DIV-1; it stays high through reset when CLK_DIV is 1.
  always_ff @(posedge clock_100 or negedge reset_n) begin
    if (!reset_n) begin
      div            <= '0;
      p_tick         <= (CLK_DIV == 1);
      x              <= '0;
      y              <= '0;
      hsync          <= ~HSYNC_POL;
      vsync          <= ~VSYNC_POL;
      display_active <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      frame_count    <= '0;
    end else begin
      div            <= div_n;
      p_tick         <= (div_n == DIV_LAST);
      x              <= x_n;
      y              <= y_n;
      hsync          <= hsync_n;
      vsync          <= vsync_n;
      display_active <= active_n;
      line_start     <= h_wrap;
      frame_start    <= v_wrap;
      if (v_wrap) frame_count <= frame_count + FRAME_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for vga_timing_gen: a default VGA instance and a
// tiny CLK_DIV=1 instance, each compared every cycle against an arithmetic model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        p_tick;
    logic [10:0] x;
    logic [10:0] y;
    logic        hsync;
    logic        vsync;
    logic        da;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {
    int d, ha, hfp, hs, hbp, va, vfp, vs, vbp;
    bit hpol, vpol;
  } cfg_t;

  // k = clock edges since reset release, n = pixel advances since reset release.
  typedef struct {
    int k;
    int n;
    bit da, ls, fs;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, en0, rst1_n, en1;
  logic p0, hs0, vs0, da0, ls0, fs0, p1, hs1, vs1, da1, ls1, fs1;
  logic [10:0] x0, y0, x1, y1;
  logic [7:0] fc0, fc1;
  obs_t act0, act1;
  assign act0 = {p0, x0, y0, hs0, vs0, da0, ls0, fs0, fc0};
  assign act1 = {p1, x1, y1, hs1, vs1, da1, ls1, fs1, fc1};

  vga_timing_gen u_dut0 (
    .clock_100(clk), .reset_n(rst0_n), .enable(en0), .p_tick(p0), .x(x0), .y(y0),
    .hsync(hs0), .vsync(vs0), .display_active(da0), .line_start(ls0),
    .frame_start(fs0), .frame_count(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CNT_W(11), .FRAME_W(8)
  ) u_dut1 (
    .clock_100(clk), .reset_n(rst1_n), .enable(en1), .p_tick(p1), .x(x1), .y(y1),
    .hsync(hs1), .vsync(vs1), .display_active(da1), .line_start(ls1),
    .frame_start(fs1), .frame_count(fc1)
  );

  obs_t q0[$];
  obs_t q1[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  bit   final_done = 1'b0;
  cfg_t c0, c1;

  function automatic mdl_t mreset();
    mdl_t m;
    m.k = 0; m.n = 0; m.da = 1'b0; m.ls = 1'b0; m.fs = 1'b0;
    return m;
  endfunction

  function automatic mdl_t step(cfg_t c, mdl_t m, bit en);
    int ht, vt;
    bit adv;
    ht  = c.ha + c.hfp + c.hs + c.hbp;
    vt  = c.va + c.vfp + c.vs + c.vbp;
    adv = en && ((m.k % c.d) == c.d - 1);
    m.k++;
    if (adv) m.n++;
    m.ls = adv && ((m.n % ht) == 0);
    m.fs = m.ls && (((m.n / ht) % vt) == 0);
    m.da = en && ((m.n % ht) < c.ha) && (((m.n / ht) % vt) < c.va);
    return m;
  endfunction

  function automatic obs_t expect_of(cfg_t c, mdl_t m);
    int ht, vt, xx, yy;
    obs_t o;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    xx = m.n % ht;
    yy = (m.n / ht) % vt;
    o.p_tick = ((m.k % c.d) == c.d - 1);
    o.x  = 11'(xx);
    o.y  = 11'(yy);
    o.hsync = (xx >= c.ha + c.hfp && xx < c.ha + c.hfp + c.hs) ? c.hpol : !c.hpol;
    o.vsync = (yy >= c.va + c.vfp && yy < c.va + c.vfp + c.vs) ? c.vpol : !c.vpol;
    o.da = m.da;
    o.ls = m.ls;
    o.fs = m.fs;
    o.fc = 8'((m.n / (ht * vt)) % 256);
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("p=%0b x=%0d y=%0d hs=%0b vs=%0b da=%0b ls=%0b fs=%0b fc=%0d",
                     o.p_tick, o.x, o.y, o.hsync, o.vsync, o.da, o.ls, o.fs, o.fc);
  endfunction

  // Monitor: pop one expectation per DUT per cycle and compare; end-of-run checks too.
  int hmin0 = 9999, hmax0 = -1, amax0 = -1, hmin1 = 9999, hmax1 = -1;
  bit wrapped1 = 1'b0;
  logic [7:0] fc1_prev = 8'd0;
  always @(negedge clk) begin
    obs_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checks++;
      if (act0 !== e) begin
        errors++;
        $display("FAIL dut0_outputs t=%0t got %s expected %s", $time, fmt(act0), fmt(e));
      end
      if (act0.hsync == 1'b0 && rst0_n) begin
        if (int'(act0.x) < hmin0) hmin0 = int'(act0.x);
        if (int'(act0.x) > hmax0) hmax0 = int'(act0.x);
      end
      if (act0.da == 1'b1 && int'(act0.x) > amax0) amax0 = int'(act0.x);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checks++;
      if (act1 !== e) begin
        errors++;
        $display("FAIL dut1_outputs t=%0t got %s expected %s", $time, fmt(act1), fmt(e));
      end
      if (act1.hsync == 1'b1) begin
        if (int'(act1.x) < hmin1) hmin1 = int'(act1.x);
        if (int'(act1.x) > hmax1) hmax1 = int'(act1.x);
      end
      if (fc1_prev == 8'd255 && act1.fc == 8'd0) wrapped1 = 1'b1;
      fc1_prev = act1.fc;
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      checks += 6;
      if (hmin0 != 656 || hmax0 != 751) begin
        errors++;
        $display("FAIL dut0_hsync_window got %0d..%0d expected 656..751", hmin0, hmax0);
      end
      if (amax0 != 639) begin
        errors++;
        $display("FAIL dut0_active_last_x got %0d expected 639", amax0);
      end
      if (hmin1 != 10 || hmax1 != 11) begin
        errors++;
        $display("FAIL dut1_hsync_window got %0d..%0d expected 10..11", hmin1, hmax1);
      end
      if (wrapped1 != 1'b1) begin
        errors++;
        $display("FAIL dut1_frame_wrap got %0b expected 1", wrapped1);
      end
      if (q0.size() != 0) begin
        errors++;
        $display("FAIL dut0_queue_drain got %0d expected 0", q0.size());
      end
      if (q1.size() != 0) begin
        errors++;
        $display("FAIL dut1_queue_drain got %0d expected 0", q1.size());
      end
    end
  end

  initial begin
    rst0_n = 1'b0; en0 = 1'b1;
    rst1_n = 1'b0; en1 = 1'b1;
    c0 = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    c1 = '{1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b0};
    fork
      begin : stim0
        mdl_t m;
        bit   dropped;
        int   hold;
        m = mreset(); dropped = 1'b0; hold = 0;
        for (int cyc = 0; cyc < 25000; cyc++) begin
          @(posedge clk);
          if (rst0_n) m = step(c0, m, en0); else m = mreset();
          #1;
          if (cyc == 3 || cyc == 21003) begin
            rst0_n = 1'b1; en0 = 1'b1;
          end else if (cyc == 21000) begin
            rst0_n = 1'b0;
          end else if (!dropped && m.n == 5 * 800 + 100) begin
            dropped = 1'b1; hold = 37; en0 = 1'b0;
          end else if (hold > 0) begin
            hold--;
            if (hold == 0) en0 = 1'b1;
          end else if (dropped && cyc < 21000) begin
            en0 = ($urandom_range(0, 7) != 0);
          end else begin
            en0 = 1'b1;
          end
          if (!rst0_n) m = mreset();
          q0.push_back(expect_of(c0, m));
        end
      end
      begin : stim1
        mdl_t m;
        m = mreset();
        for (int cyc = 0; cyc < 28000; cyc++) begin
          @(posedge clk);
          if (rst1_n) m = step(c1, m, en1); else m = mreset();
          #1;
          if (cyc == 2 || cyc == 152) rst1_n = 1'b1;
          else if (cyc == 150) rst1_n = 1'b0;
          en1 = ($urandom_range(0, 31) != 0);
          if (!rst1_n) m = mreset();
          q1.push_back(expect_of(c1, m));
        end
      end
    join
    repeat (2) @(negedge clk);
    done = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- CLK_DIV, 4, clock cycles per pixel, range 1 to 16
- HSYNC_POL, 0, asserted hsync level
- VSYNC_POL, 0, asserted vsync level
- CNT_W, 11, x and y width
- FRAME_W, 8, frame counter width

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock_100, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- enable, in, 1, timing run/freeze
- p_tick, out, 1, pixel-advance strobe
- x, out, CNT_W, horizontal count
- y, out, CNT_W, vertical count
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- display_active, out, 1, pixel in visible area
- line_start, out, 1, one-clock pulse at x wrap to 0
- frame_start, out, 1, one-clock pulse at (0,0)
- frame_count, out, FRAME_W, frames started, modulo 2^FRAME_W

REQ-003 The block SHALL have one clock, clock_100; reset_n SHALL be asynchronous and active-low.

Function
REQ-004 Divider SHALL count 0 to CLK_DIV-1 and wrap; p_tick SHALL be high exactly when the divider equals CLK_DIV-1. With CLK_DIV=1, p_tick SHALL be constantly high out of reset.
REQ-005 The divider SHALL run regardless of enable.
REQ-006 Counters SHALL advance only on a clock where p_tick=1 and enable=1 ("advance").
REQ-007 Horizontal max SHALL be HT-1, where HT = H_ACTIVE+H_FP+H_SYNC+H_BP. On advance: x at HT-1 goes to 0, otherwise x increments.
REQ-008 y SHALL change only on an advance where x=HT-1. Vertical max SHALL be VT-1, where VT = V_ACTIVE+V_FP+V_SYNC+V_BP. y at VT-1 wraps to 0, otherwise y increments.
REQ-009 hsync SHALL equal HSYNC_POL when x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and !HSYNC_POL otherwise. vsync SHALL follow the same rule on y using the V parameters and VSYNC_POL.
REQ-010 display_active SHALL be 1 iff x<H_ACTIVE, y<V_ACTIVE and enable=1.
REQ-011 hsync, vsync and display_active SHALL be registered, decoded from next-state counts. They SHALL have zero cycle skew relative to x and y.
REQ-012 line_start SHALL pulse for exactly one clock_100 cycle, in the cycle x becomes 0 via wrap.
REQ-013 frame_start SHALL pulse for exactly one clock_100 cycle, in the cycle (x,y) becomes (0,0) via wrap. line_start SHALL also pulse in that cycle.
REQ-014 frame_count SHALL increment on the clock frame_start is asserted, wrapping 2^FRAME_W-1 to 0.
REQ-015 With enable=0, x, y, hsync, vsync and frame_count SHALL hold. display_active, line_start and frame_start SHALL be 0 from the next clock. On re-enable, counting SHALL resume from the held counts with no skipped or repeated pixel.
REQ-016 Parameters with CNT_W too small for HT-1 or VT-1, or CLK_DIV outside 1 to 16, SHALL be rejected at elaboration.

Reset
REQ-017 While reset_n=0, all outputs SHALL be forced immediately to their reset values:
- divider = 0, x = 0, y = 0, frame_count = 0
- display_active, line_start, frame_start and p_tick = 0 (p_tick = 1 if CLK_DIV=1)
- hsync = !HSYNC_POL, vsync = !VSYNC_POL
REQ-018 Reset asserted mid-frame SHALL abandon the frame. After release, timing SHALL restart at (0,0) with no frame_start pulse for the aborted frame.
REQ-019 After release with enable=1, the first advance SHALL occur on the CLK_DIV-th clock edge.

Verification
REQ-020 Defaults, release reset, enable=1:
- p_tick high on clock edges 4, 8, 12, and so on.
- x reaches 799 then 0, with line_start pulsing once; y becomes 1.
REQ-021 Defaults, sweep one line:
- hsync=0 for exactly x = 656..751 (96 pixel times) and 1 elsewhere.
- display_active=1 for x = 0..639 only.
REQ-022 Defaults, run 2 frames:
- vsync=0 only for y = 490..491.
- frame_start pulses every 1,680,000 clocks.
- frame_count goes 0 to 1 to 2.
REQ-023 Drop enable at x=100, y=5 for 37 clocks:
- x and y hold at 100 and 5; display_active drops to 0 next clock.
- After re-enable, the next advance gives x=101 and display_active=1.
REQ-024 Pulse reset_n low at y=300:
- All outputs take reset values asynchronously.
- Restart at (0,0); frame_count = 0.
REQ-025 Set CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, HSYNC_POL=1:
- Line is 14 clocks, frame is 98 clocks.
- hsync=1 for x = 10..11.
- frame_count wraps after 256 frames with FRAME_W=8.
